// File: rtl/hacc_array.sv
// rtl/hacc_array.sv - windowed per-channel popcount accumulator array
// Each window sums popcounts over 2**OWID enabled cycles and publishes saturated totals.
module hacc_array #(
  parameter int IDIM = 4,
  parameter int ADIM = 32,
  parameter int OWID = 8,
  parameter int IWID = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             iStart,
  input  logic                             iEn,
  input  logic [ADIM-1:0][IDIM-1:0]        iBit,
  output logic                             oBusy,
  output logic                             oValid,
  output logic [IDIM-1:0][IWID-1:0]        oData
);

  localparam int WLEN = 2 ** OWID;
  localparam int AWID = $clog2(ADIM * WLEN + 1);
  localparam int PWID = $clog2(ADIM + 1);
  // One spare bit so the saturation compare never needs a zero-width slice.
  localparam int SWID = ((AWID > IWID) ? AWID : IWID) + 1;
  localparam logic [SWID-1:0] OMAX = (SWID'(1) << IWID) - SWID'(1);
  localparam logic [OWID:0]   LAST = (OWID + 1)'(WLEN - 1);
  localparam logic [OWID:0]   ONE  = (OWID + 1)'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                        state, state_n;
  logic [OWID:0]                 cnt;
  logic [IDIM-1:0][AWID-1:0]     acc;
  logic [IDIM-1:0][AWID-1:0]     acc_sum;
  logic [IDIM-1:0][PWID-1:0]     pop;
  logic                          clear;
  logic                          count_en;
  logic                          done;

  function automatic logic [IWID-1:0] sat(input logic [AWID-1:0] v);
    logic [SWID-1:0] w;
    w = SWID'(v);
    if (w > OMAX) return '1;
    return w[IWID-1:0];
  endfunction

  always_comb begin
    for (int c = 0; c < IDIM; c++) begin
      pop[c] = '0;
      for (int a = 0; a < ADIM; a++) begin
        pop[c] = pop[c] + PWID'(iBit[a][c]);
      end
      acc_sum[c] = acc[c] + AWID'(pop[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clear    = 1'b0;
    count_en = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          clear   = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (iEn) begin
          count_en = 1'b1;
          // This counted cycle brings the counter to WLEN and is itself included.
          if (cnt == LAST) begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      oValid <= 1'b0;
      oData  <= '0;
    end else begin
      oValid <= done;
      if (clear) begin
        cnt <= '0;
        acc <= '0;
      end else if (count_en) begin
        cnt <= cnt + ONE;
        acc <= acc_sum;
      end
      if (done) begin
        for (int c = 0; c < IDIM; c++) begin
          oData[c] <= sat(acc_sum[c]);
        end
      end
    end
  end

  assign oBusy = (state == RUN);

endmodule

// File: tb/tb_hacc_array.sv
// tb/tb_hacc_array.sv - self-checking bench for hacc_array
// Drives default and IWID=12 instances in parallel against a window-sum reference.
module tb_hacc_array;

  localparam int IDIM = 4;
  localparam int ADIM = 32;
  localparam int WLEN = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst, iStart, iEn;
  logic [ADIM-1:0][IDIM-1:0]     iBit;
  logic                          busy, valid, busy12, valid12;
  logic [IDIM-1:0][15:0]         data;
  logic [IDIM-1:0][11:0]         data12;

  int checks = 0;
  int errors = 0;
  int exp_cnt[IDIM];
  int prev_cnt[IDIM];

  hacc_array dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iEn(iEn), .iBit(iBit),
    .oBusy(busy), .oValid(valid), .oData(data)
  );

  hacc_array #(.IWID(12)) dut12 (
    .clk(clk), .rst(rst), .iStart(iStart), .iEn(iEn), .iBit(iBit),
    .oBusy(busy12), .oValid(valid12), .oData(data12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sat12(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic gen_bits(input int mode);
    for (int a = 0; a < ADIM; a++)
      for (int c = 0; c < IDIM; c++)
        case (mode)
          0:       iBit[a][c] = 1'b0;
          1:       iBit[a][c] = 1'b1;
          2:       iBit[a][c] = (a < ((c == 2) ? 17 : 16));
          default: iBit[a][c] = 1'($urandom_range(0, 1));
        endcase
  endtask

  task automatic check_data(input string tag);
    for (int c = 0; c < IDIM; c++) begin
      chk($sformatf("%s_data%0d", tag, c), 32'(data[c]), 32'(prev_cnt[c]));
      chk($sformatf("%s_data12_%0d", tag, c), 32'(data12[c]), 32'(sat12(prev_cnt[c])));
    end
  endtask

  // Starts a window, feeds WLEN counted cycles (with an optional contiguous gap
  // at mid-window) and checks the result pulse that follows the last counted cycle.
  task automatic run_window(input int mode, input int gaps, input bit stray_start);
    int counted, gaps_left, cycles;
    iStart = 1'b1;
    iEn    = 1'($urandom_range(0, 1));
    gen_bits(3);
    tick;
    iStart = 1'b0;
    chk("busy_start", 32'(busy), 32'd1);
    chk("valid_after_start", 32'(valid), 32'd0);
    check_data("hold_start");
    exp_cnt   = '{default: 0};
    counted   = 0;
    gaps_left = gaps;
    cycles    = 0;
    while (counted < WLEN && cycles < WLEN + gaps + 10) begin
      gen_bits(mode);
      if (gaps_left > 0 && counted == WLEN / 2) begin
        iEn = 1'b0;
        gaps_left--;
      end else begin
        iEn = 1'b1;
      end
      iStart = stray_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (iEn)
        for (int c = 0; c < IDIM; c++)
          for (int a = 0; a < ADIM; a++)
            exp_cnt[c] += int'(iBit[a][c]);
      tick;
      cycles++;
      if (iEn) counted++;
      if (counted < WLEN) begin
        chk("valid_early", 32'(valid), 32'd0);
        chk("busy_run", 32'(busy), 32'd1);
      end
    end
    iStart = 1'b0;
    iEn    = 1'b0;
    chk("window_cycles", 32'(cycles), 32'(WLEN + gaps));
    chk("valid_pulse", 32'(valid), 32'd1);
    chk("valid12_pulse", 32'(valid12), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    prev_cnt = exp_cnt;
    check_data("result");
  endtask

  task automatic idle_check;
    tick;
    chk("valid_drop", 32'(valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    check_data("hold_idle");
  endtask

  initial begin
    int counted;
    rst      = 1'b1;
    iStart   = 1'b0;
    iEn      = 1'b0;
    iBit     = '0;
    prev_cnt = '{default: 0};
    tick;
    iStart = 1'b1;
    iEn    = 1'b1;
    gen_bits(1);
    tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    check_data("rst");
    rst    = 1'b0;
    iStart = 1'b0;
    tick;
    chk("no_start_after_rst", 32'(busy), 32'd0);

    run_window(0, 0, 1'b0);
    idle_check;
    run_window(1, 0, 1'b0);
    idle_check;
    run_window(2, 0, 1'b1);
    run_window(3, 10, 1'b1);
    run_window(3, 0, 1'b0);
    idle_check;

    iStart = 1'b1;
    tick;
    iStart  = 1'b0;
    counted = 0;
    for (int i = 0; i < 100; i++) begin
      gen_bits(3);
      iEn    = 1'b1;
      iStart = 1'($urandom_range(0, 1));
      tick;
      counted++;
    end
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst    = 1'b1;
    iStart = 1'b0;
    tick;
    rst      = 1'b0;
    prev_cnt = '{default: 0};
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    check_data("midrst");
    for (int i = 0; i < 300; i++) begin
      gen_bits(3);
      iEn = 1'b1;
      tick;
      chk("post_rst_valid", 32'(valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    check_data("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hacc_array.md
HACC_ARRAY -- requirements
Module: hacc_array

Interface
REQ-001 The block SHALL have parameter IDIM, default 4, meaning the number of output channels.
REQ-002 The block SHALL have parameter ADIM, default 32, meaning the number of bitstream inputs accumulated per channel per cycle.
REQ-003 The block SHALL have parameter OWID, default 8, meaning log2 of the window length; the window is WLEN = 2**OWID counted cycles.
REQ-004 The block SHALL have parameter IWID, default 16, meaning the width of each accumulated output word.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 The block SHALL have port iStart, input, 1 bit, a one-cycle request to begin a window.
REQ-008 The block SHALL have port iEn, input, 1 bit, qualifying the current cycle's bits for counting.
REQ-009 The block SHALL have port iBit, input, ADIM x IDIM bits, where iBit[a][c] is bitstream a of channel c.
REQ-010 The block SHALL have port oBusy, input-independent output, 1 bit, high while a window is in progress.
REQ-011 The block SHALL have port oValid, output, 1 bit, a one-cycle pulse marking a new result.
REQ-012 The block SHALL have port oData, output, IDIM x IWID bits, holding the per-channel counts of the last completed window.

Function
REQ-013 The block SHALL implement two states: IDLE and RUN.
REQ-014 In IDLE, iStart=1 SHALL clear all accumulators and the cycle counter and move to RUN on the next edge; iBit in that cycle is not counted.
REQ-015 In RUN, every cycle with iEn=1 SHALL add popcount(iBit[*][c]) to accumulator c and increment the cycle counter; cycles with iEn=0 SHALL leave accumulators and the counter unchanged.
REQ-016 The counted cycle that brings the counter to WLEN SHALL be included, and on that same edge accumulators SHALL be copied to oData, oValid SHALL be 1 for the following cycle, and the state SHALL return to IDLE.
REQ-017 iStart asserted in RUN SHALL be ignored.
REQ-018 iStart asserted in the cycle oValid is high SHALL start a new window normally, giving back-to-back windows with one non-counting gap cycle.
REQ-019 oBusy SHALL equal 1 exactly while the state is RUN.
REQ-020 The accumulators SHALL be at least clog2(ADIM*WLEN+1) bits wide internally; the oData value SHALL saturate at 2**IWID-1 if the count exceeds it.
REQ-021 For unipolar input, oData[c] equals the number of ones; for bipolar input, ADIM*WLEN/2 represents zero, matching the downstream activation stage's zero point.
REQ-022 oData SHALL hold its value between windows and change only on the completion edge.
REQ-023 Latency from the final counted cycle to oValid=1 SHALL be exactly 1 cycle.

Reset
REQ-024 While rst=1, the block SHALL force IDLE, oBusy=0, oValid=0, all oData words to 0, and all accumulators and the counter to 0, taking priority over iStart and iEn.
REQ-025 Reset asserted mid-window SHALL discard the partial window with no oValid pulse and leave oData at 0.

Verification
REQ-026 Defaults; iStart, then 256 cycles of iEn=1 with all iBit=0 -> oValid pulse 1 cycle after the 256th, all oData=0, oBusy low afterwards.
REQ-027 Defaults; all iBit=1 for 256 counted cycles -> oData[c]=8192 for every channel.
REQ-028 Defaults; 16 of 32 bits high per channel every cycle -> oData[c]=4096; channel 2 with 17 high -> oData[2]=4352.
REQ-029 Defaults; iEn low for 10 cycles inside the window -> oValid arrives 10 cycles later, same counts as with no gaps.
REQ-030 iStart pulsed during RUN and rst pulsed at counted cycle 100 -> no restart on iStart; after rst, oValid never pulses, oData=0, oBusy=0.
REQ-031 IWID=12 with all ones -> oData saturates at 4095.
